detector_event_controller: RTL and testbench

Acquisition sequencer for the 64-channel detector front end. It arms on a run request and opens a coincidence window on the first hit. It accumulates an OR'd hit mask over that window, timestamps the event and ships it as one AXI4-Stream beat. It then enforces a programmable dead time, counts delivered and dropped events, and stops after a programmable event limit. It sits between the clock-domain-crossed detector bus and the DMA/stream path.

---
 rtl/detector_event_controller.sv | 200 ++++++++++++++++++++
 tb/tb_detector_event_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/detector_event_controller.sv
// ---------------------------------------------------------------------------
// detector_event_controller
//
// Acquisition sequencer for the 64-channel detector front end. Once run is
// high it arms and waits for the first hit. The first hit opens a coincidence
// window, and hit bits are OR'd into a mask across that window. The event is
// timestamped and sent as a single AXI4-Stream beat {timestamp, hit_mask}.
// After the beat it waits out a programmable dead time, then re-arms. It stops
// once a programmable event limit is reached.
//
// Ports:
//   aclk, aresetn     clock; synchronous active-low reset
//   det_data[63:0]    detector hit bits, already in the aclk domain
//   run               1 = acquire, 0 = stop
//   cfg_window        coincidence window length W (sampled when arming)
//   cfg_dead          dead time D in cycles (sampled when arming)
//   cfg_limit         event limit L, 0 = unlimited (sampled when arming)
//   m_axis_*          event stream output, one beat per event
//   sts_events        events delivered since the last arm (saturating)
//   sts_dropped       triggers lost while busy (saturating)
//   busy              controller is not idle
//   done              event limit reached; cleared on the next arm
// ---------------------------------------------------------------------------
module detector_event_controller #(
  parameter int TS_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [63:0]            det_data,
  input  logic                   run,
  input  logic [7:0]             cfg_window,
  input  logic [7:0]             cfg_dead,
  input  logic [CNT_WIDTH-1:0]   cfg_limit,
  output logic [TS_WIDTH+63:0]   m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [CNT_WIDTH-1:0]   sts_events,
  output logic [CNT_WIDTH-1:0]   sts_dropped,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    WINDOW = 3'd2,
    SEND   = 3'd3,
    DEAD   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                 state_reg;
  logic [TS_WIDTH-1:0]    timer_reg;
  logic [TS_WIDTH-1:0]    ts_reg;
  logic [63:0]            mask_reg;
  logic [7:0]             window_cnt_reg;
  logic [7:0]             dead_cnt_reg;
  logic [7:0]             cfg_window_reg;
  logic [7:0]             cfg_dead_reg;
  logic [CNT_WIDTH-1:0]   cfg_limit_reg;
  logic [TS_WIDTH+63:0]   tdata_reg;
  logic                   tvalid_reg;
  logic [CNT_WIDTH-1:0]   events_reg;
  logic [CNT_WIDTH-1:0]   dropped_reg;
  logic                   done_reg;
  logic                   edge_reg;

  logic                   hit;
  logic                   hit_rise;
  logic                   handshake;
  logic                   drop_state;
  logic [CNT_WIDTH-1:0]   events_inc;
  logic                   limit_hit;

  assign hit        = |det_data;
  assign hit_rise   = hit & ~edge_reg;
  assign handshake  = tvalid_reg & m_axis_tready;
  assign drop_state = (state_reg == SEND) || (state_reg == DEAD) || (state_reg == DONE);

  // Saturating increment of the delivered-event count.
  assign events_inc = (events_reg == {CNT_WIDTH{1'b1}}) ? events_reg : events_reg + 1'b1;
  // The limit check uses the post-handshake count.
  assign limit_hit  = (cfg_limit_reg != '0) && (events_inc == cfg_limit_reg);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      ts_reg         <= '0;
      mask_reg       <= '0;
      window_cnt_reg <= '0;
      dead_cnt_reg   <= '0;
      cfg_window_reg <= '0;
      cfg_dead_reg   <= '0;
      cfg_limit_reg  <= '0;
      tdata_reg      <= '0;
      tvalid_reg     <= 1'b0;
      events_reg     <= '0;
      dropped_reg    <= '0;
      done_reg       <= 1'b0;
      edge_reg       <= 1'b0;
    end else begin
      edge_reg  <= hit;
      timer_reg <= (state_reg == IDLE) ? '0 : timer_reg + 1'b1;

      // A new trigger that arrives while an event is still in flight, or after
      // the limit is reached, is lost. Count it here.
      if (drop_state && hit_rise && (dropped_reg != {CNT_WIDTH{1'b1}}))
        dropped_reg <= dropped_reg + 1'b1;

      case (state_reg)
        IDLE: begin
          if (run) begin
            cfg_window_reg <= cfg_window;
            cfg_dead_reg   <= cfg_dead;
            cfg_limit_reg  <= cfg_limit;
            events_reg     <= '0;
            dropped_reg    <= '0;
            done_reg       <= 1'b0;
            state_reg      <= ARMED;
          end
        end

        ARMED: begin
          if (!run) begin
            state_reg <= IDLE;
          end else if (hit) begin
            mask_reg       <= det_data;
            ts_reg         <= timer_reg;
            window_cnt_reg <= '0;
            state_reg      <= WINDOW;
          end
        end

        WINDOW: begin
          if (!run) begin
            // A partial window is discarded.
            state_reg <= IDLE;
          end else begin
            mask_reg <= mask_reg | det_data;
            if (window_cnt_reg >= cfg_window_reg) begin
              // This cycle's sample closes the window and goes into the beat.
              tdata_reg  <= {ts_reg, mask_reg | det_data};
              tvalid_reg <= 1'b1;
              state_reg  <= SEND;
            end else begin
              window_cnt_reg <= window_cnt_reg + 1'b1;
            end
          end
        end

        SEND: begin
          // Stay here until the beat is accepted, even if run has dropped.
          if (handshake) begin
            tvalid_reg <= 1'b0;
            events_reg <= events_inc;
            if (limit_hit) begin
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else if (!run) begin
              state_reg <= IDLE;
            end else if (cfg_dead_reg == 8'd0) begin
              state_reg <= ARMED;
            end else begin
              dead_cnt_reg <= '0;
              state_reg    <= DEAD;
            end
          end
        end

        DEAD: begin
          if (!run) begin
            state_reg <= IDLE;
          end else if (dead_cnt_reg == cfg_dead_reg - 8'd1) begin
            state_reg <= ARMED;
          end else begin
            dead_cnt_reg <= dead_cnt_reg + 1'b1;
          end
        end

        DONE: begin
          // done stays set in IDLE so the result can be read out.
          if (!run)
            state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign sts_events    = events_reg;
  assign sts_dropped   = dropped_reg;
  assign busy          = (state_reg != IDLE);
  assign done          = done_reg;

endmodule

// File: tb/tb_detector_event_controller.sv
// ---------------------------------------------------------------------------
// tb_detector_event_controller
//
// Directed stimulus with a scoreboard. Each expected beat {ts, mask} is queued
// when its stimulus is issued. A separate monitor pops the queue on every
// accepted beat and compares. Status outputs are checked directly from the
// stimulus process at fixed points.
// ---------------------------------------------------------------------------
module tb_detector_event_controller;

  logic         aclk;
  logic         aresetn;
  logic [63:0]  det_data;
  logic         run;
  logic [7:0]   cfg_window;
  logic [7:0]   cfg_dead;
  logic [31:0]  cfg_limit;
  logic [95:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [31:0]  sts_events;
  logic [31:0]  sts_dropped;
  logic         busy;
  logic         done;

  detector_event_controller #(
    .TS_WIDTH  (32),
    .CNT_WIDTH (32)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .det_data      (det_data),
    .run           (run),
    .cfg_window    (cfg_window),
    .cfg_dead      (cfg_dead),
    .cfg_limit     (cfg_limit),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .sts_events    (sts_events),
    .sts_dropped   (sts_dropped),
    .busy          (busy),
    .done          (done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic [95:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic arm(input logic [7:0] w, input logic [7:0] d, input logic [31:0] l);
    cfg_window = w;
    cfg_dead   = d;
    cfg_limit  = l;
    run        = 1'b1;
    tick();
  endtask

  // Monitor: one line and one comparison per accepted beat.
  initial begin
    logic [95:0] e;
    forever begin
      @(negedge aclk);
      if (aresetn && m_axis_tvalid && m_axis_tready) begin
        $display("beat ts=%0d mask=%016h", m_axis_tdata[95:64], m_axis_tdata[63:0]);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected no beat", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat", m_axis_tdata, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0; run = 1'b0; det_data = '0; m_axis_tready = 1'b1;
    cfg_window = '0; cfg_dead = '0; cfg_limit = '0;
    repeat (3) tick();
    chk("rst_tvalid",  m_axis_tvalid, 0);
    chk("rst_tdata",   m_axis_tdata,  0);
    chk("rst_events",  sts_events,    0);
    chk("rst_dropped", sts_dropped,   0);
    chk("rst_busy",    busy,          0);
    chk("rst_done",    done,          0);
    aresetn = 1'b1;
    tick();

    // 1: W=3, samples T..T+4 OR'd, T+5 excluded, ts=3
    arm(8'd3, 8'd0, 32'd0);
    exp_q.push_back({32'd3, 64'h8000_0000_0000_0101});
    det_data = '0; repeat (3) tick();
    det_data = 64'h1;                   tick();
    det_data = '0;                      tick();
    det_data = 64'h100;                 tick();
    det_data = '0;                      tick();
    det_data = 64'h8000_0000_0000_0000; tick();
    det_data = 64'h2;                   tick();
    det_data = '0;                      tick();
    chk("t1_events",  sts_events,  1);
    chk("t1_dropped", sts_dropped, 0);
    run = 1'b0; tick();
    chk("t1_idle_busy", busy, 0);

    // 2: W=0, stalled SEND with three hit pulses
    arm(8'd0, 8'd0, 32'd0);
    m_axis_tready = 1'b0;
    exp_q.push_back({32'd0, 64'h15});
    det_data = 64'h5;  tick();
    det_data = 64'h10; tick();
    det_data = '0;     tick();
    for (int i = 0; i < 10; i++) begin
      det_data = (i == 0 || i == 2 || i == 4) ? 64'h1 : 64'h0;
      tick();
      chk("t2_stall_tvalid", m_axis_tvalid, 1);
      chk("t2_stall_tdata",  m_axis_tdata,  {32'd0, 64'h15});
    end
    det_data = '0; m_axis_tready = 1'b1; tick();
    tick();
    chk("t2_events",  sts_events,  1);
    chk("t2_dropped", sts_dropped, 3);
    run = 1'b0; tick();

    // 3: W=1, D=5, continuous hits, beats W+8 = 9 cycles apart
    arm(8'd1, 8'd5, 32'd0);
    det_data = 64'hFF;
    exp_q.push_back({32'd0,  64'hFF});
    exp_q.push_back({32'd9,  64'hFF});
    exp_q.push_back({32'd18, 64'hFF});
    repeat (23) tick();
    run = 1'b0; tick();
    det_data = '0;
    chk("t3_busy",    busy,        0);
    chk("t3_events",  sts_events,  3);
    chk("t3_dropped", sts_dropped, 0);

    // 4: L=2, event limit reached, then readout, then re-arm
    arm(8'd0, 8'd0, 32'd2);
    det_data = 64'h1;
    exp_q.push_back({32'd0, 64'h1});
    exp_q.push_back({32'd3, 64'h1});
    repeat (10) tick();
    chk("t4_done",   done,       1);
    chk("t4_busy",   busy,       1);
    chk("t4_events", sts_events, 2);
    det_data = '0;   tick();
    det_data = 64'h1; tick();
    det_data = '0;   tick();
    chk("t4_dropped", sts_dropped, 1);
    run = 1'b0; tick();
    chk("t4_idle_busy",    busy,        0);
    chk("t4_idle_done",    done,        1);
    chk("t4_idle_events",  sts_events,  2);
    chk("t4_idle_dropped", sts_dropped, 1);
    arm(8'd5, 8'd0, 32'd0);
    chk("t4_rearm_done",    done,        0);
    chk("t4_rearm_events",  sts_events,  0);
    chk("t4_rearm_dropped", sts_dropped, 0);
    chk("t4_rearm_busy",    busy,        1);

    // 5a: run dropped mid-window, so no beat is sent
    det_data = 64'h40; tick();
    det_data = '0;     repeat (2) tick();
    run = 1'b0; tick();
    chk("t5_busy",   busy,          0);
    chk("t5_events", sts_events,    0);
    chk("t5_tvalid", m_axis_tvalid, 0);
    repeat (8) tick();

    // 5b: run dropped during stalled SEND, so IDLE only after the handshake
    arm(8'd0, 8'd0, 32'd0);
    m_axis_tready = 1'b0;
    exp_q.push_back({32'd0, 64'h3});
    det_data = 64'h3; tick();
    det_data = '0;    repeat (2) tick();
    run = 1'b0; repeat (3) tick();
    chk("t5b_stall_busy",   busy,          1);
    chk("t5b_stall_tvalid", m_axis_tvalid, 1);
    m_axis_tready = 1'b1; tick();
    chk("t5b_busy",   busy,          0);
    chk("t5b_tvalid", m_axis_tvalid, 0);
    chk("t5b_events", sts_events,    1);

    // 6: reset asserted during a stalled SEND
    arm(8'd0, 8'd0, 32'd0);
    det_data = 64'h1;
    exp_q.push_back({32'd0, 64'h1});
    repeat (3) tick();
    m_axis_tready = 1'b0;
    repeat (3) tick();
    chk("t6_pre_tvalid", m_axis_tvalid, 1);
    chk("t6_pre_events", sts_events,    1);
    aresetn = 1'b0; run = 1'b0; tick();
    chk("t6_tvalid",  m_axis_tvalid, 0);
    chk("t6_tdata",   m_axis_tdata,  0);
    chk("t6_events",  sts_events,    0);
    chk("t6_dropped", sts_dropped,   0);
    chk("t6_busy",    busy,          0);
    chk("t6_done",    done,          0);
    aresetn = 1'b1; det_data = '0; m_axis_tready = 1'b1;
    repeat (3) tick();

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
